// File: rtl/arbitro_memoria_compartilhada_if.sv
// Bus bundle between the shared-memory arbiter, the IF/MEM pipeline stages and the memory.
// slave = arbiter view, master = pipeline/memory view.
interface arbitro_memoria_compartilhada_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] address;
    logic [31:0] dadoW;
    logic        lerMem;
    logic        escMem;
    logic [31:0] Mem_out;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, Mem_out,
        output if_rdata, if_ready, d_rdata, d_ready, address, dadoW,
               lerMem, escMem, stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, Mem_out,
        input  if_rdata, if_ready, d_rdata, d_ready, address, dadoW,
               lerMem, escMem, stall_if, stall_mem, busy
    );
endinterface

// File: rtl/arbitro_memoria_compartilhada.sv
// Arbiter/sequencer for the single-port shared instruction/data memory; data has priority.
// Optional ARB_STARVE_GUARD_EN: after MAX_DATA_RUN data grants with IF waiting, IF is served.
module arbitro_memoria_compartilhada #(
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input logic                            clock,
    input logic                            reset,
    arbitro_memoria_compartilhada_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]  state_q,     state_d;
    logic        grant_d_q,   grant_d_d;    // 1 = data requester owns the transaction
    logic        is_write_q,  is_write_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [31:0] address_q,   address_d;
    logic [31:0] dadoW_q,     dadoW_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;

    logic d_req;
    logic force_if;

    assign d_req = bus.d_rd | bus.d_wr;

`ifdef ARB_STARVE_GUARD_EN
    localparam int RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    logic [RUN_W-1:0] run_q, run_d;

    assign force_if = bus.if_req && (run_q == RUN_MAX);

    always_comb begin
        run_d = run_q;
        if (state_q == S_IDLE) begin
            if (d_req && !force_if) begin
                // Saturates at the limit; at the limit a waiting IF wins the next grant anyway.
                if (bus.if_req && (run_q != RUN_MAX))
                    run_d = run_q + 1'b1;
            end else if (bus.if_req) begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) run_q <= '0;
        else       run_q <= run_d;
    end
`else
    assign force_if = 1'b0;
`endif

    // NOTE: every next-state signal starts from its flop value, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        grant_d_d  = grant_d_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        address_d  = address_q;
        dadoW_d    = dadoW_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (d_req && !force_if) begin
                    grant_d_d  = 1'b1;
                    is_write_d = bus.d_wr;      // rd+wr together is a store
                    address_d  = bus.d_addr;
                    dadoW_d    = bus.d_wdata;
                    cnt_d      = CNT_INIT;
                    state_d    = S_ACCESS;
                end else if (bus.if_req) begin
                    grant_d_d  = 1'b0;
                    is_write_d = 1'b0;
                    address_d  = bus.if_addr;
                    cnt_d      = CNT_INIT;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!grant_d_q)
                        if_rdata_d = bus.Mem_out;
                    else if (!is_write_q)
                        d_rdata_d = bus.Mem_out;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_d_q  <= 1'b0;
            is_write_q <= 1'b0;
            cnt_q      <= 4'd0;
            address_q  <= 32'd0;
            dadoW_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            grant_d_q  <= grant_d_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
            address_q  <= address_d;
            dadoW_q    <= dadoW_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Strobes and ready pulses decode registered state, so a reset drops them at the same edge.
    assign bus.address   = address_q;
    assign bus.dadoW     = dadoW_q;
    assign bus.lerMem    = (state_q == S_ACCESS) && !is_write_q;
    assign bus.escMem    = (state_q == S_ACCESS) &&  is_write_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = (state_q == S_DONE) && !grant_d_q;
    assign bus.d_ready   = (state_q == S_DONE) &&  grant_d_q;
    assign bus.stall_if  = bus.if_req && !((state_q == S_DONE) && !grant_d_q);
    assign bus.stall_mem = d_req      && !((state_q == S_DONE) &&  grant_d_q);
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_arbitro_memoria_compartilhada.sv
// Directed bench for arbitro_memoria_compartilhada: vector table on a MEM_LAT=1 instance
// plus hand sequences for contention, MEM_LAT=3 timing, mid-access reset and grant fairness.
module tb_arbitro_memoria_compartilhada;

    logic clock = 1'b0;
    logic rst1;
    logic rst3;

    always #5 clock = ~clock;

    arbitro_memoria_compartilhada_if bus1 ();
    arbitro_memoria_compartilhada_if bus3 ();

    arbitro_memoria_compartilhada #(.MEM_LAT(1), .MAX_DATA_RUN(2)) u1 (
        .clock (clock),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    arbitro_memoria_compartilhada #(.MEM_LAT(3), .MAX_DATA_RUN(2)) u3 (
        .clock (clock),
        .reset (rst3),
        .bus   (bus3.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        if_req;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        exp_ler;
        logic        exp_esc;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle1();
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_rd = 1'b0; bus1.d_wr = 1'b0;
        bus1.d_addr = '0;   bus1.d_wdata = '0; bus1.Mem_out = '0;
    endtask

    task automatic idle3();
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_rd = 1'b0; bus3.d_wr = 1'b0;
        bus3.d_addr = '0;   bus3.d_wdata = '0; bus3.Mem_out = '0;
    endtask

    logic        is_d;
    int          n;
    int          seen;
    int          ler_cnt;
    logic        flag;
    logic [5:0]  got_order;
    logic [5:0]  exp_order;
    int          k;

    initial begin
        // fetch, store, load, rd+wr (store), fetch at top of map, unaligned store
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h8C01_0004, 1'b1, 1'b0, 32'h8C01_0004, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b1, 32'h8C01_0004, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 32'h8C01_0004, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_C0DE, 32'h2222_2222, 1'b0, 1'b1, 32'h8C01_0004, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0013, 1'b1, 1'b0, 32'h0000_0013, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h3333_3333, 1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D};

        idle1();
        idle3();
        rst1 = 1'b1;
        rst3 = 1'b1;
        tick();
        tick();
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Reset state
        check("rst_busy1",     bus1.busy,      1'b0);
        check("rst_ler1",      bus1.lerMem,    1'b0);
        check("rst_esc1",      bus1.escMem,    1'b0);
        check("rst_ready1",    {bus1.if_ready, bus1.d_ready}, 2'b00);
        check("rst_stall1",    {bus1.stall_if, bus1.stall_mem}, 2'b00);
        check("rst_address1",  bus1.address,   32'h0);
        check("rst_dadoW1",    bus1.dadoW,     32'h0);
        check("rst_if_rdata1", bus1.if_rdata,  32'h0);
        check("rst_d_rdata1",  bus1.d_rdata,   32'h0);
        check("rst_busy3",     bus3.busy,      1'b0);

        // Single-requester transactions, MEM_LAT=1
        for (int i = 0; i < 6; i++) begin
            is_d = vecs[i].d_rd | vecs[i].d_wr;
            bus1.if_req  = vecs[i].if_req;
            bus1.d_rd    = vecs[i].d_rd;
            bus1.d_wr    = vecs[i].d_wr;
            bus1.if_addr = vecs[i].addr;
            bus1.d_addr  = vecs[i].addr;
            bus1.d_wdata = vecs[i].wdata;
            bus1.Mem_out = vecs[i].mem;
            #1;
            check($sformatf("v%0d_stall_idle", i), is_d ? bus1.stall_mem : bus1.stall_if, 1'b1);
            tick();
            check($sformatf("v%0d_address", i), bus1.address, vecs[i].addr);
            check($sformatf("v%0d_ler", i),     bus1.lerMem,  vecs[i].exp_ler);
            check($sformatf("v%0d_esc", i),     bus1.escMem,  vecs[i].exp_esc);
            check($sformatf("v%0d_busy", i),    bus1.busy,    1'b1);
            check($sformatf("v%0d_stall_acc", i), is_d ? bus1.stall_mem : bus1.stall_if, 1'b1);
            if (vecs[i].exp_esc)
                check($sformatf("v%0d_dadoW", i), bus1.dadoW, vecs[i].wdata);
            tick();
            check($sformatf("v%0d_if_ready", i), bus1.if_ready, !is_d);
            check($sformatf("v%0d_d_ready", i),  bus1.d_ready,  is_d);
            check($sformatf("v%0d_strobes_done", i), {bus1.lerMem, bus1.escMem}, 2'b00);
            check($sformatf("v%0d_stall_done", i), {bus1.stall_if, bus1.stall_mem}, 2'b00);
            check($sformatf("v%0d_if_rdata", i), bus1.if_rdata, vecs[i].exp_if_rdata);
            check($sformatf("v%0d_d_rdata", i),  bus1.d_rdata,  vecs[i].exp_d_rdata);
            idle1();
            tick();
            check($sformatf("v%0d_idle_busy", i), bus1.busy, 1'b0);
            check($sformatf("v%0d_idle_ready", i), {bus1.if_ready, bus1.d_ready}, 2'b00);
        end

        // Contention: data first, IF three cycles after d_ready
        bus1.if_req = 1'b1; bus1.if_addr = 32'h44;
        bus1.d_rd   = 1'b1; bus1.d_addr  = 32'h208;
        bus1.Mem_out = 32'h3333_3333;
        tick();
        check("cont_data_addr", bus1.address,  32'h208);
        check("cont_stall_if1", bus1.stall_if, 1'b1);
        tick();
        check("cont_d_ready",   bus1.d_ready,  1'b1);
        check("cont_if_ready0", bus1.if_ready, 1'b0);
        check("cont_stall_if2", bus1.stall_if, 1'b1);
        check("cont_d_rdata",   bus1.d_rdata,  32'h3333_3333);
        bus1.d_rd = 1'b0;
        bus1.Mem_out = 32'h4444_4444;
        seen = 0;
        flag = 1'b1;
        for (n = 1; n <= 10 && seen == 0; n++) begin
            tick();
            if (bus1.if_ready) seen = n;
            else if (!bus1.stall_if) flag = 1'b0;
        end
        check("cont_if_gap",    32'(seen),     32'd3);
        check("cont_stall_held", flag,         1'b1);
        check("cont_if_rdata",  bus1.if_rdata, 32'h4444_4444);
        check("cont_if_addr",   bus1.address,  32'h44);
        idle1();
        tick();

        // MEM_LAT=3 load: only the last ACCESS cycle's Mem_out may be captured
        bus3.d_rd = 1'b1; bus3.d_addr = 32'h80;
        bus3.Mem_out = 32'hBAD0_0000;
        seen = 0;
        ler_cnt = 0;
        for (n = 1; n <= 10 && seen == 0; n++) begin
            tick();
            if (bus3.lerMem) ler_cnt++;
            if (bus3.d_ready) seen = n;
            bus3.Mem_out = (n == 3) ? 32'h1234_5678 : (32'hBAD0_0000 | 32'(n));
        end
        check("lat3_ready_edge", 32'(seen),    32'd4);
        check("lat3_ler_cycles", 32'(ler_cnt), 32'd3);
        check("lat3_d_rdata",    bus3.d_rdata, 32'h1234_5678);
        idle3();
        tick();

        // Reset in the middle of a MEM_LAT=3 store
        bus3.d_wr = 1'b1; bus3.d_addr = 32'h100; bus3.d_wdata = 32'hDEAD_BEEF;
        tick();
        tick();
        check("rstmid_esc_before", bus3.escMem, 1'b1);
        rst3 = 1'b1;
        bus3.d_wr = 1'b0;
        tick();
        rst3 = 1'b0;
        check("rstmid_busy",    bus3.busy,    1'b0);
        check("rstmid_esc",     bus3.escMem,  1'b0);
        check("rstmid_d_ready", bus3.d_ready, 1'b0);
        flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus3.d_ready || bus3.busy) flag = 1'b1;
        end
        check("rstmid_no_pulse", flag, 1'b0);
        check("rstmid_d_rdata", bus3.d_rdata, 32'h0);

        // Both requesters held: grant order on the MAX_DATA_RUN=2 instance
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h50;
        bus1.d_rd   = 1'b1; bus1.d_addr  = 32'h60;
        got_order = '0;
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            tick();
            if (bus1.d_ready || bus1.if_ready) begin
                got_order[k] = bus1.d_ready;
                k++;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        exp_order = 6'b011011;   // bit0 first: D, D, I, D, D, I
`else
        exp_order = 6'b111111;   // strict data priority
`endif
        check("order_count", 32'(k), 32'd6);
        for (int j = 0; j < 6; j++)
            check($sformatf("order_%0d_is_data", j), got_order[j], exp_order[j]);
        idle1();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
